univ_counter_reg: RTL and testbench

//   Parametrised, clocked successor to the 8-bit universal counter cell:
//   a WIDTH-bit register with hold / count-up / count-down / parallel load,

---
 rtl/univ_counter_reg.sv | 94 +++++++++
 tb/tb_univ_counter_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/univ_counter_reg.sv
// Universal WIDTH-bit counter/register with hold, up, down, load, shift and clear modes.
// A programmable wrap point and carry chaining allow modulo and multi-digit counters.
module univ_counter_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cin,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             sout,
    output logic [2:0]       mout
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_UP    = 3'b001,
        MODE_DOWN  = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_SHL   = 3'b100,
        MODE_SHR   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    mode_e            w_mode;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic             w_atTop;
    logic             w_atZero;
    logic             w_cout;
    logic             w_sout;

    assign w_mode   = mode_e'(mode);
    // Values loaded above MOD_MAX count as "at top" so the next up-count wraps to 0.
    assign w_atTop  = (r_q >= MOD_MAX);
    assign w_atZero = (r_q == '0);

    always_comb begin
        w_next = r_q;
        case (w_mode)
            MODE_HOLD:  w_next = r_q;
            MODE_UP: begin
                if (cin) begin
                    w_next = w_atTop ? '0 : r_q + WIDTH'(1);
                end
            end
            MODE_DOWN: begin
                if (cin) begin
                    w_next = w_atZero ? MOD_MAX : r_q - WIDTH'(1);
                end
            end
            MODE_LOAD:  w_next = pin;
            MODE_SHL:   w_next = {r_q[WIDTH-2:0], sin};
            MODE_SHR:   w_next = {sin, r_q[WIDTH-1:1]};
            MODE_CLEAR: w_next = '0;
            MODE_RSVD:  w_next = r_q;
            default:    w_next = r_q;
        endcase
    end

    always_comb begin
        w_cout = 1'b0;
        w_sout = 1'b0;
        case (w_mode)
            MODE_UP:   w_cout = cin & w_atTop;
            MODE_DOWN: w_cout = cin & w_atZero;
            MODE_SHL:  w_sout = r_q[WIDTH-1];
            MODE_SHR:  w_sout = r_q[0];
            default: begin
                w_cout = 1'b0;
                w_sout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign q    = r_q;
    assign cout = w_cout;
    assign sout = w_sout;
    assign mout = mode;

endmodule

// File: tb/tb_univ_counter_reg.sv
// Directed bench for univ_counter_reg: an 8-bit instance, a 4-bit modulo-10 instance
// and a two-digit cascade of modulo-10 stages, all sharing clock and reset.
module tb_univ_counter_reg;

    logic       clk;
    logic       rst;

    logic       cin8;
    logic [2:0] mode8;
    logic [7:0] pin8;
    logic       sin8;
    logic [7:0] q8;
    logic       cout8;
    logic       sout8;
    logic [2:0] mout8;

    logic       cin4;
    logic [2:0] mode4;
    logic [3:0] pin4;
    logic       sin4;
    logic [3:0] q4;
    logic       cout4;
    logic       sout4;
    logic [2:0] mout4;

    logic       cascCin;
    logic [2:0] cascMode;
    logic [3:0] cascPin;
    logic       cascSin;
    logic [3:0] loQ;
    logic       loCout;
    logic       loSout;
    logic [2:0] loMout;
    logic [3:0] hiQ;
    logic       hiCout;
    logic       hiSout;
    logic [2:0] hiMout;

    int testsRun  = 0;
    int failCount = 0;

    univ_counter_reg #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .cin(cin8), .mode(mode8), .pin(pin8), .sin(sin8),
        .q(q8), .cout(cout8), .sout(sout8), .mout(mout8)
    );

    univ_counter_reg #(.WIDTH(4), .MOD_MAX(4'd9)) u4 (
        .clk(clk), .rst(rst), .cin(cin4), .mode(mode4), .pin(pin4), .sin(sin4),
        .q(q4), .cout(cout4), .sout(sout4), .mout(mout4)
    );

    univ_counter_reg #(.WIDTH(4), .MOD_MAX(4'd9)) uLo (
        .clk(clk), .rst(rst), .cin(cascCin), .mode(cascMode), .pin(cascPin), .sin(cascSin),
        .q(loQ), .cout(loCout), .sout(loSout), .mout(loMout)
    );

    univ_counter_reg #(.WIDTH(4), .MOD_MAX(4'd9)) uHi (
        .clk(clk), .rst(rst), .cin(loCout), .mode(loMout), .pin(cascPin), .sin(cascSin),
        .q(hiQ), .cout(hiCout), .sout(hiSout), .mout(hiMout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int expLo;
        int expHi;
        rst      = 1'b0;
        cin8     = 1'b0; mode8 = 3'b000; pin8 = 8'h00; sin8 = 1'b0;
        cin4     = 1'b0; mode4 = 3'b000; pin4 = 4'h0; sin4 = 1'b0;
        cascCin  = 1'b0; cascMode = 3'b000; cascPin = 4'h0; cascSin = 1'b0;

        #2;
        checkOutput("reset_q8", q8, 8'h00);
        checkOutput("reset_cout8", {7'd0, cout8}, 8'h00);
        checkOutput("reset_sout8", {7'd0, sout8}, 8'h00);
        checkOutput("reset_q4", {4'd0, q4}, 8'h00);
        tick();
        tick();
        rst = 1'b1;

        // Asynchronous reset mid-cycle from a non-zero value.
        mode8 = 3'b011; pin8 = 8'hC6;
        tick();
        checkOutput("load_c6", q8, 8'hC6);
        mode8 = 3'b000;
        #3 rst = 1'b0;
        #1;
        checkOutput("async_reset", q8, 8'h00);
        mode8 = 3'b010; cin8 = 1'b1;
        #1;
        checkOutput("reset_cout_down", {7'd0, cout8}, 8'h01);
        checkOutput("reset_sout_down", {7'd0, sout8}, 8'h00);
        tick();
        checkOutput("reset_held", q8, 8'h00);
        mode8 = 3'b001; cin8 = 1'b1;
        rst = 1'b1;
        tick();
        checkOutput("release_up", q8, 8'h01);
        mode8 = 3'b110;
        tick();
        checkOutput("sync_clear", q8, 8'h00);

        // Count enable gating.
        mode8 = 3'b001; cin8 = 1'b0;
        repeat (3) tick();
        checkOutput("up_cin0", q8, 8'h00);
        checkOutput("mout8", {5'd0, mout8}, 8'h01);
        cin8 = 1'b1;
        repeat (5) tick();
        checkOutput("up_five", q8, 8'h05);
        checkOutput("up_five_cout", {7'd0, cout8}, 8'h00);

        // Wrap up and down at full range.
        mode8 = 3'b011; pin8 = 8'hFF;
        tick();
        checkOutput("load_ff", q8, 8'hFF);
        mode8 = 3'b001; cin8 = 1'b1;
        #1;
        checkOutput("up_wrap_cout", {7'd0, cout8}, 8'h01);
        tick();
        checkOutput("up_wrap_q", q8, 8'h00);
        mode8 = 3'b010;
        #1;
        checkOutput("down_wrap_cout", {7'd0, cout8}, 8'h01);
        tick();
        checkOutput("down_wrap_q", q8, 8'hFF);
        checkOutput("down_ff_cout", {7'd0, cout8}, 8'h00);
        cin8 = 1'b0;
        tick();
        checkOutput("down_cin0", q8, 8'hFF);

        // Load and shifts.
        mode8 = 3'b011; pin8 = 8'hA5;
        tick();
        checkOutput("load_a5", q8, 8'hA5);
        checkOutput("load_sout", {7'd0, sout8}, 8'h00);
        mode8 = 3'b100; sin8 = 1'b1;
        #1;
        checkOutput("shl_sout", {7'd0, sout8}, 8'h01);
        tick();
        checkOutput("shl_q", q8, 8'h4B);
        mode8 = 3'b101; sin8 = 1'b0;
        #1;
        checkOutput("shr_sout", {7'd0, sout8}, 8'h01);
        tick();
        checkOutput("shr_q", q8, 8'h25);
        mode8 = 3'b111;
        tick();
        checkOutput("reserved_hold", q8, 8'h25);
        mode8 = 3'b000;
        tick();
        checkOutput("hold", q8, 8'h25);

        // Modulo-10 counting on the 4-bit instance.
        mode4 = 3'b001; cin4 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            checkOutput("mod_cout", {7'd0, cout4}, (i == 10) ? 8'h01 : 8'h00);
            tick();
            checkOutput("mod_q", {4'd0, q4}, (i == 10) ? 8'h00 : 8'(i));
        end
        mode4 = 3'b011; pin4 = 4'hC;
        tick();
        checkOutput("mod_load_c", {4'd0, q4}, 8'h0C);
        mode4 = 3'b001;
        #1;
        checkOutput("mod_over_cout", {7'd0, cout4}, 8'h01);
        tick();
        checkOutput("mod_over_up", {4'd0, q4}, 8'h00);
        mode4 = 3'b011;
        tick();
        mode4 = 3'b010;
        tick();
        checkOutput("mod_over_down", {4'd0, q4}, 8'h0B);

        // Two-digit decimal cascade 00..99 then wrap.
        cascMode = 3'b001; cascCin = 1'b1;
        for (int n = 1; n <= 103; n++) begin
            tick();
            expLo = n % 10;
            expHi = (n / 10) % 10;
            checkOutput("casc_lo", {4'd0, loQ}, 8'(expLo));
            checkOutput("casc_hi", {4'd0, hiQ}, 8'(expHi));
        end
        cascMode = 3'b111;
        tick();
        checkOutput("casc_hold_lo", {4'd0, loQ}, 8'h03);
        checkOutput("casc_hold_hi", {4'd0, hiQ}, 8'h00);
        cascMode = 3'b011; cascPin = 4'h5;
        tick();
        cascMode = 3'b110;
        tick();
        checkOutput("casc_clear_lo", {4'd0, loQ}, 8'h00);
        checkOutput("casc_clear_hi", {4'd0, hiQ}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
